// File: rtl/seq_playback.sv
// Sequence playback: replays sequence RAM entries 0..len-1 as one-hot LED flashes separated by dark gaps.
// Latency: first read address one cycle after start, LED lit two cycles later, each entry takes 2+ON+OFF cycles.
// Backpressure: none; start is only honoured in IDLE and ignored while busy or in the DONE cycle.
module seq_playback #(
    parameter int IDX_W      = 8,
    parameter int ON_CYCLES  = 3,   // must be >= 1
    parameter int OFF_CYCLES = 2    // must be >= 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] len,
    output logic [IDX_W-1:0] rd_addr,
    input  logic [1:0]       rd_data,
    output logic [3:0]       led,
    output logic             busy,
    output logic             done
);

    // Timer only has to hold the larger of the two reload values (count-1).
    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SHOW  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] len_q;
    logic [IDX_W-1:0] last_idx;
    logic [TW-1:0]    timer;
    logic [3:0]       led_q;
    logic             timer_zero;
    logic             is_last;

    // Colour code to one-hot LED pattern.
    function automatic logic [3:0] decode(input logic [1:0] code);
        logic [3:0] onehot;
        onehot = 4'b0000;
        onehot[code] = 1'b1;
        return onehot;
    endfunction

    // len_q is never zero outside IDLE/DONE, so last_idx is only used when it is meaningful.
    assign last_idx   = len_q - IDX_W'(1);
    assign is_last    = (idx == last_idx);
    assign timer_zero = (timer == '0);

    // Next-state selection; inputs only steer transitions, never outputs directly.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (len != '0) ? S_FETCH : S_DONE;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_SHOW;
            S_SHOW:  if (timer_zero) state_nxt = S_GAP;
            S_GAP:   if (timer_zero) state_nxt = is_last ? S_DONE : S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any playback in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Length is captured once per run so later changes on len cannot alter it.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
        end else if (state == S_IDLE && start) begin
            len_q <= len;
        end
    end

    // Index walks 0..len_q-1, advancing only at the end of a gap; cleared in IDLE and DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else begin
            case (state)
                S_IDLE:  idx <= '0;
                S_DONE:  idx <= '0;
                S_GAP:   if (timer_zero && !is_last) idx <= idx + IDX_W'(1);
                default: idx <= idx;
            endcase
        end
    end

    // Shared down-counter: loaded with the on-time in WAIT, the off-time at the end of SHOW.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else begin
            case (state)
                S_WAIT:  timer <= ON_LOAD;
                S_SHOW:  timer <= timer_zero ? OFF_LOAD : (timer - TW'(1));
                S_GAP:   if (!timer_zero) timer <= timer - TW'(1);
                default: timer <= timer;
            endcase
        end
    end

    // LED register: loaded from RAM data in WAIT, held through SHOW, dark otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= 4'b0000;
        end else begin
            case (state)
                S_WAIT:  led_q <= decode(rd_data);
                S_SHOW:  if (timer_zero) led_q <= 4'b0000;
                default: led_q <= 4'b0000;
            endcase
        end
    end

    assign rd_addr = idx;
    assign led     = led_q;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_seq_playback.sv
`timescale 1ns/1ps
module tb_seq_playback;

    localparam int IDX_W = 8;
    localparam int ON    = 3;
    localparam int OFF   = 2;
    localparam int P     = 2 + ON + OFF;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic [IDX_W-1:0] len   = '0;
    logic [IDX_W-1:0] rd_addr;
    logic [1:0]       rd_data;
    logic [3:0]       led;
    logic             busy;
    logic             done;

    logic [1:0] mem [256];

    int checks = 0;
    int errors = 0;

    seq_playback #(.IDX_W(IDX_W), .ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .led     (led),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Sequence RAM with one cycle of read latency.
    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A run accepted at edge kk occupies spec cycles kk+1 .. kk+1+mlen*P.
    int edge_n = 0;
    int kk     = 0;
    int mlen   = 0;
    bit active = 0;

    function automatic bit m_busy(input int e);
        int d;
        d = e - kk;
        return active && (d >= 0) && (d <= mlen * P);
    endfunction

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (rst) begin
            active = 0;
        end else if (start && !m_busy(edge_n - 1)) begin
            active = 1;
            kk     = edge_n;
            mlen   = int'(len);
        end
    end

    // Compare DUT against the model on every cycle once the first edge has occurred.
    always @(negedge clk) begin
        int t, i, ph;
        int e_led, e_addr, e_busy, e_done;
        if (edge_n >= 1) begin
            e_led = 0; e_addr = 0; e_busy = 0; e_done = 0;
            if (active) begin
                t = edge_n - kk + 1;
                if (t >= 1 && t <= mlen * P) begin
                    i  = (t - 1) / P;
                    ph = (t - 1) % P;
                    e_busy = 1;
                    e_addr = i;
                    if (ph >= 2 && ph < 2 + ON) e_led = 1 << mem[i];
                end else if (t == mlen * P + 1) begin
                    e_busy = 1;
                    e_done = 1;
                    e_addr = (mlen == 0) ? 0 : mlen - 1;
                end
            end
            check("model_led",     int'(led),     e_led);
            check("model_rd_addr", int'(rd_addr), e_addr);
            check("model_busy",    int'(busy),    e_busy);
            check("model_done",    int'(done),    e_done);
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        int done_cnt;
        for (int a = 0; a < 256; a++) mem[a] = 2'b00;
        mem[0] = 2'b01; mem[1] = 2'b11; mem[2] = 2'b00;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_led", int'(led), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // Run 1: len=3; a start during DONE must be ignored, the one in the first IDLE cycle accepted
        len = 8'd3; start = 1'b1;
        for (int j = 1; j <= 23; j++) begin
            @(negedge clk);
            if (j == 1) begin
                start = 1'b0;
                check("r1_busy_k1", int'(busy), 1);
                check("r1_addr_k1", int'(rd_addr), 0);
            end
            if (j == 2)  check("r1_led_k2", int'(led), 0);
            if (j == 3)  check("r1_led_k3", int'(led), 4'b0010);
            if (j == 5)  check("r1_led_k5", int'(led), 4'b0010);
            if (j == 6)  check("r1_led_k6", int'(led), 0);
            if (j == 8)  check("r1_addr_k8", int'(rd_addr), 1);
            if (j == 10) check("r1_led_k10", int'(led), 4'b1000);
            if (j == 12) check("r1_led_k12", int'(led), 4'b1000);
            if (j == 17) check("r1_led_k17", int'(led), 4'b0001);
            if (j == 19) check("r1_led_k19", int'(led), 4'b0001);
            if (j == 20) check("r1_led_k20", int'(led), 0);
            if (j == 21) check("r1_done_k21", int'(done), 0);
            if (j == 22) begin
                check("r1_done_k22", int'(done), 1);
                start = 1'b1;
            end
            if (j == 23) begin
                check("r1_done_k23", int'(done), 0);
                check("r1_busy_k23", int'(busy), 0);
            end
        end

        // Run 2 (back-to-back): re-start and len change while busy must not disturb it
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            if (j == 1) begin
                start = 1'b0;
                check("r2_addr_k1", int'(rd_addr), 0);
                check("r2_busy_k1", int'(busy), 1);
            end
            if (j == 3)  check("r2_led_k3", int'(led), 4'b0010);
            if (j == 5)  begin start = 1'b1; len = 8'd1; end
            if (j == 6)  start = 1'b0;
            if (j == 10) check("r2_led_k10", int'(led), 4'b1000);
            if (j == 17) check("r2_led_k17", int'(led), 4'b0001);
            if (j == 21) check("r2_done_k21", int'(done), 0);
            if (j == 22) check("r2_done_k22", int'(done), 1);
            if (j == 24) check("r2_busy_k24", int'(busy), 0);
        end

        // len = 0: immediate done, nothing lit, no address movement
        len = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("z_done_k1", int'(done), 1);
        check("z_busy_k1", int'(busy), 1);
        check("z_led_k1", int'(led), 0);
        check("z_addr_k1", int'(rd_addr), 0);
        @(negedge clk);
        check("z_done_k2", int'(done), 0);
        check("z_busy_k2", int'(busy), 0);

        // start together with reset: stays idle
        len = 8'd3; rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("rs_busy_a", int'(busy), 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rs_busy_b", int'(busy), 0);

        // Reset mid-SHOW: abort, no done afterwards
        len = 8'd3; start = 1'b1;
        done_cnt = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            if (j == 4) begin
                check("ab_led_k4", int'(led), 4'b0010);
                rst = 1'b1;
            end
            if (j == 5) begin
                check("ab_led_k5", int'(led), 0);
                check("ab_busy_k5", int'(busy), 0);
                check("ab_done_k5", int'(done), 0);
                check("ab_addr_k5", int'(rd_addr), 0);
            end
            if (j == 6) rst = 1'b0;
            if (j >= 5 && done) done_cnt++;
        end
        check("ab_no_done", done_cnt, 0);

        // len = 1
        mem[0] = 2'b10;
        len = 8'd1; start = 1'b1;
        for (int j = 1; j <= P + 2; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            if (j == 3) check("one_led_k3", int'(led), 4'b0100);
            if (j == P) check("one_done_kP", int'(done), 0);
            if (j == P + 1) check("one_done_kP1", int'(done), 1);
            if (j == P + 2) check("one_busy_kP2", int'(busy), 0);
        end

        // Maximum length: entries 0..254, no wrap
        for (int a = 0; a < 256; a++) mem[a] = 2'($urandom_range(0, 3));
        len = 8'd255; start = 1'b1;
        for (int j = 1; j <= 255 * P + 2; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            if (j == 1 + 254 * P) check("max_addr_last", int'(rd_addr), 254);
            if (j == 255 * P) check("max_done_early", int'(done), 0);
            if (j == 255 * P + 1) begin
                check("max_done", int'(done), 1);
                check("max_addr_done", int'(rd_addr), 254);
            end
            if (j == 255 * P + 2) check("max_idle_addr", int'(rd_addr), 0);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_playback.md
# seq_playback

Sequence playback engine for the memory game: on command, reads the stored colour sequence from the sequence RAM at indices 0 to len-1 and shows each entry on the one-hot LED outputs for a fixed on-time, followed by a dark gap. It is the read side of the sequence store. The index-advance/append logic writes that store; this block walks the same index space to replay it to the player. It sits between the game controller (start/done handshake) and the LED drivers.

## Interface
- IDX_W, 8: width of the sequence index and length.
- ON_CYCLES, 3: clock cycles each LED stays lit; must be ≥1.
- OFF_CYCLES, 2: dark clock cycles after each LED; must be ≥1.

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin playback; sampled only in IDLE.
- len  in  IDX_W  number of entries to play; latched when start is accepted.
- rd_addr  out  IDX_W  sequence RAM read address; equals the internal index register.
- rd_data  in  2  RAM read data; valid one cycle after rd_addr is presented.
- led  out  4  one-hot colour display: 00→0001, 01→0010, 10→0100, 11→1000.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when playback completes.

## Operation
- States: IDLE, FETCH, WAIT, SHOW, GAP, DONE.
- IDLE: idx=0, led=0. On start=1:
  - len_q<=len.
  - If len≠0, go to FETCH.
  - If len=0, go directly to DONE. No RAM read occurs and no LED lights.
- FETCH: rd_addr=idx is presented. Next state is WAIT.
- WAIT: rd_data is valid. Actions at the end of the cycle:
  - led<=decode(rd_data).
  - timer<=ON_CYCLES-1.
  - Next state is SHOW.
- SHOW: led holds its value. Timer decrements each cycle. When timer=0:
  - led<=0.
  - timer<=OFF_CYCLES-1.
  - Next state is GAP.
- GAP: led=0. Timer decrements each cycle. When timer=0:
  - If idx==len_q-1, go to DONE.
  - Otherwise idx<=idx+1 and go to FETCH.
- DONE: done=1 for this single cycle. Actions at the end of the cycle:
  - idx<=0.
  - Next state is IDLE.
- Index arithmetic is IDX_W-bit unsigned. len=2^IDX_W-1 plays entries 0..254 with no wrap. idx never exceeds len_q-1.
- The timer is wide enough for max(ON_CYCLES, OFF_CYCLES)-1.
- start while busy is ignored, and len changes while busy have no effect.
- A start in the DONE cycle is ignored. A new start is accepted from the first IDLE cycle.
- rst=1 forces IDLE on the next edge regardless of state (mid-playback abort). Reset values:
  - led=0, idx=0, rd_addr=0.
  - busy=0, done=0.
  - timer=0, len_q=0.
- rst takes priority over a simultaneous start.

## Timing
- Start is accepted at edge k. busy=1 from cycle k+1.
- Each step lasts 2+ON_CYCLES+OFF_CYCLES cycles: FETCH, WAIT, SHOW×ON, GAP×OFF.
- Entry i:
  - rd_addr=i is presented in cycle k+1+i·P, where P=2+ON+OFF.
  - led is lit in cycles k+3+i·P through k+2+ON+i·P.
- done pulses in cycle k+1+len·P. busy falls in cycle k+2+len·P.
- len=0: done pulses in cycle k+1. busy is high only in that cycle.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst for 2 cycles mid-SHOW with len=3.
  - Next cycle: led=0, busy=0, done=0, rd_addr=0.
  - No done pulse follows.
- Playback of len=3 with RAM {0:2'b01, 1:2'b11, 2:2'b00}, ON=3, OFF=2, start at edge k.
  - led=0010 in cycles k+3..k+5, then 1000 in k+10..k+12, then 0001 in k+17..k+19.
  - done in cycle k+22 only.
- len=0 with start: done=1 in the next cycle, led stays 0, rd_addr stays 0.
- Start pulsed again while busy, and len changed mid-run: playback length and timing are unchanged from the first start.
- Start asserted together with rst=1: block stays IDLE, busy=0.
- Back-to-back runs: start in the first IDLE cycle after done. The second run begins at rd_addr=0 with the same timing as the first.
